// File: rtl/dpram_tdp_param_if.sv
// Single-port access bundle for dpram_tdp_param: enable, write enable,
// sync set/reset, address, write data and registered read data.
interface dpram_tdp_param_if #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 13
);
  logic              en;
  logic              we;
  logic              ssr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, output we, output ssr, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input ssr, input addr, input wdata, output rdata);
endinterface

// File: rtl/dpram_tdp_param.sv
// Single-clock true dual-port RAM with per-port write mode (WRITE_FIRST,
// READ_FIRST, NO_CHANGE), per-port SSR value and A-wins collision handling.
// Optional collision pulse/counter enabled by defining DPRAM_COLLISION_CNT_EN.
module dpram_tdp_param #(
  parameter int unsigned       DATA_W  = 2,
  parameter int unsigned       ADDR_W  = 13,
  parameter int unsigned       WMODE_A = 0,
  parameter int unsigned       WMODE_B = 0,
  parameter logic [DATA_W-1:0] SRVAL_A = '0,
  parameter logic [DATA_W-1:0] SRVAL_B = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dpram_tdp_param_if.slave      a,
  dpram_tdp_param_if.slave      b,
  output logic                  coll_pulse,
  output logic [15:0]           coll_count
);
  typedef enum int unsigned {
    WRITE_FIRST = 0,
    READ_FIRST  = 1,
    NO_CHANGE   = 2
  } wmode_e;

  localparam wmode_e      MODE_A = wmode_e'(WMODE_A);
  localparam wmode_e      MODE_B = wmode_e'(WMODE_B);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              same_addr;
  logic              a_wr;
  logic              b_wr;
  logic              b_blocked;

  assign same_addr = (a.addr == b.addr);
  assign a_wr      = a.en & a.we;
  assign b_wr      = b.en & b.we;
  // Both ports writing one word: A's data is stored, B's is dropped.
  assign b_blocked = a_wr & b_wr & same_addr;

  // Array write ports; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (a_wr)
      mem[a.addr] <= a.wdata;
    if (b_wr && !b_blocked)
      mem[b.addr] <= b.wdata;
  end

  // Port A output register; array reads return the pre-edge word, which
  // also gives the cross-port read-first result when B writes the same word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= SRVAL_A;
    end else if (a.en) begin
      if (a.ssr) begin
        a_q <= SRVAL_A;
      end else if (a.we) begin
        case (MODE_A)
          WRITE_FIRST: a_q <= a.wdata;
          READ_FIRST:  a_q <= mem[a.addr];
          NO_CHANGE:   a_q <= a_q;
          default:     a_q <= a_q;
        endcase
      end else begin
        a_q <= mem[a.addr];
      end
    end
  end

  // Port B output register; in WRITE_FIRST a lost collision returns the
  // word A actually stored rather than B's discarded data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_q <= SRVAL_B;
    end else if (b.en) begin
      if (b.ssr) begin
        b_q <= SRVAL_B;
      end else if (b.we) begin
        case (MODE_B)
          WRITE_FIRST: b_q <= b_blocked ? a.wdata : b.wdata;
          READ_FIRST:  b_q <= mem[b.addr];
          NO_CHANGE:   b_q <= b_q;
          default:     b_q <= b_q;
        endcase
      end else begin
        b_q <= mem[b.addr];
      end
    end
  end

  assign a.rdata = a_q;
  assign b.rdata = b_q;

`ifdef DPRAM_COLLISION_CNT_EN
  logic coll;
  assign coll = a.en & b.en & same_addr & (a.we | b.we);

  // Collision pulse and saturating counter, cleared only by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_pulse <= 1'b0;
      coll_count <= '0;
    end else begin
      coll_pulse <= coll;
      if (coll && (coll_count != '1))
        coll_count <= coll_count + 16'd1;
    end
  end
`else
  assign coll_pulse = 1'b0;
  assign coll_count = '0;
`endif
endmodule
